// File: rtl/pe_pkg.sv
// Shared widths, default lane count and FSM state type for the requant transmit path.
// Optional ReLU clamp is enabled by defining ACC_REQUANT_RELU_EN.
package pe_pkg;

   localparam int ACC_W     = 32;
   localparam int OUT_W     = 16;
   localparam int DEF_LANES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      QUANT = 2'd1,
      SEND  = 2'd2
   } state_t;

endpackage

// File: rtl/requant_lane.sv
// One lane of rounding arithmetic right shift followed by 16-bit saturation.
// Defining ACC_REQUANT_RELU_EN clamps negative saturated results to zero.
module requant_lane import pe_pkg::*; #(
   parameter int SHIFT_W = 5
) (
   input  logic [ACC_W-1:0]   i_acc,
   input  logic [SHIFT_W-1:0] i_shift,
   output logic [OUT_W-1:0]   o_result
);

   localparam int EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [EXT_W-1:0] SAT_MIN = -SAT_MAX - EXT_W'(1);

   logic signed [EXT_W-1:0] w_ext;
   logic signed [EXT_W-1:0] w_half;
   logic signed [EXT_W-1:0] w_sum;
   logic signed [EXT_W-1:0] w_rnd;
   logic signed [OUT_W-1:0] w_sat;

   // The extra bit keeps acc + half-LSB from overflowing; with shift 0 half is 0.
   always_comb begin
      w_ext  = {i_acc[ACC_W-1], i_acc};
      w_half = '0;
      if (i_shift != '0) begin
         w_half = EXT_W'(1) << (i_shift - SHIFT_W'(1));
      end
      w_sum = w_ext + w_half;
      w_rnd = w_sum >>> i_shift;
      if (w_rnd > SAT_MAX) begin
         w_sat = SAT_MAX[OUT_W-1:0];
      end else if (w_rnd < SAT_MIN) begin
         w_sat = SAT_MIN[OUT_W-1:0];
      end else begin
         w_sat = w_rnd[OUT_W-1:0];
      end
`ifdef ACC_REQUANT_RELU_EN
      if (w_sat[OUT_W-1]) begin
         w_sat = '0;
      end
`endif
      o_result = w_sat;
   end

endmodule

// File: rtl/acc_requant_tx.sv
// Accepts a pack of accumulators, requantizes all lanes in one cycle, then streams them out.
// Defining ACC_REQUANT_RELU_EN enables the ReLU clamp inside each requant_lane.
module acc_requant_tx import pe_pkg::*; #(
   parameter int LANES   = DEF_LANES,
   parameter int SHIFT_W = 5
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   acc_valid,
   output logic                   acc_ready,
   input  logic [ACC_W*LANES-1:0] acc_4pack,
   input  logic                   acc_last,
   input  logic [SHIFT_W-1:0]     shift,
   output logic [OUT_W-1:0]       m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   busy
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   state_t                 r_state;
   state_t                 w_nextState;
   logic [ACC_W*LANES-1:0] r_acc;
   logic                   r_last;
   logic [SHIFT_W-1:0]     r_shift;
   logic [OUT_W-1:0]       r_result [LANES];
   logic [OUT_W-1:0]       w_result [LANES];
   logic [LW-1:0]          r_lane;
   logic                   w_accept;
   logic                   w_beat;
   logic                   w_lastLane;

   // Lanes work from the captured pack so later input changes cannot leak in.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      requant_lane #(.SHIFT_W(SHIFT_W)) u_lane (
         .i_acc    (r_acc[g*ACC_W +: ACC_W]),
         .i_shift  (r_shift),
         .o_result (w_result[g])
      );
   end

   assign w_accept   = acc_valid && acc_ready;
   assign w_beat     = m_axis_tvalid && m_axis_tready;
   assign w_lastLane = (r_lane == LW'(LANES - 1));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = QUANT;
         QUANT:   w_nextState = SEND;
         SEND:    if (w_beat && w_lastLane) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      acc_ready     = (r_state == IDLE);
      busy          = (r_state != IDLE);
      m_axis_tvalid = (r_state == SEND);
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      if (r_state == SEND) begin
         m_axis_tdata = r_result[r_lane];
         m_axis_tlast = r_last && w_lastLane;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_acc    <= '0;
         r_last   <= 1'b0;
         r_shift  <= '0;
         r_lane   <= '0;
         r_result <= '{default: '0};
      end else begin
         if (w_accept) begin
            r_acc   <= acc_4pack;
            r_last  <= acc_last;
            r_shift <= shift;
         end
         if (r_state == QUANT) begin
            r_result <= w_result;
            r_lane   <= '0;
         end else if (w_beat) begin
            r_lane <= w_lastLane ? '0 : r_lane + LW'(1);
         end
      end
   end

endmodule

// File: tb/tb_acc_requant_tx.sv
// Randomized self-checking bench for acc_requant_tx against an arithmetic reference model.
// Expected values follow the ReLU clamp when ACC_REQUANT_RELU_EN is defined.
module tb_acc_requant_tx;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic         accValid = 1'b0;
   logic         accReady;
   logic [127:0] accPack = '0;
   logic         accLast = 1'b0;
   logic [4:0]   shiftIn = '0;
   logic [15:0]  mTdata;
   logic         mTvalid;
   logic         mTready = 1'b1;
   logic         mTlast;
   logic         busy;

   int totalCount = 0;
   int badCount = 0;

   acc_requant_tx #(.LANES(4), .SHIFT_W(5)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .acc_valid     (accValid),
      .acc_ready     (accReady),
      .acc_4pack     (accPack),
      .acc_last      (accLast),
      .shift         (shiftIn),
      .m_axis_tdata  (mTdata),
      .m_axis_tvalid (mTvalid),
      .m_axis_tready (mTready),
      .m_axis_tlast  (mTlast),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Round half up of acc / 2^sh (floor of the biased value), then clamp to int16.
   function automatic longint refRequant(input int acc, input int sh);
      longint v;
      v = longint'(acc);
      if (sh > 0) begin
         v = (v + (longint'(1) << (sh - 1))) >>> sh;
      end
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`ifdef ACC_REQUANT_RELU_EN
      if (v < 0) v = 0;
`endif
      return v;
   endfunction

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_tvalid"}, longint'(mTvalid), 0);
      checkOutput({tag, "_tlast"}, longint'(mTlast), 0);
      checkOutput({tag, "_tdata"}, longint'(mTdata), 0);
      checkOutput({tag, "_busy"}, longint'(busy), 0);
   endtask

   // Offers one pack, then walks every beat; abortAfter >= 0 pulses reset after that lane.
   task automatic applyStimulus(input int vals[4], input int sh, input bit last,
                                input int stallLane, input int stallCycles,
                                input bit randStall, input int abortAfter);
      longint expV[4];
      int     waitCnt;
      int     stalls;
      for (int i = 0; i < 4; i++) expV[i] = refRequant(vals[i], sh);
      waitCnt = 0;
      while (!accReady && waitCnt < 20) begin
         tick();
         waitCnt++;
      end
      checkOutput("ready_before_accept", longint'(accReady), 1);
      for (int i = 0; i < 4; i++) accPack[i*32 +: 32] = vals[i];
      shiftIn  = 5'(sh);
      accLast  = last;
      accValid = 1'b1;
      tick();
      accValid = 1'b0;
      accPack  = {$urandom, $urandom, $urandom, $urandom};
      shiftIn  = 5'($urandom_range(0, 31));
      accLast  = 1'($urandom_range(0, 1));
      checkOutput("quant_tvalid", longint'(mTvalid), 0);
      checkOutput("quant_busy", longint'(busy), 1);
      checkOutput("quant_ready", longint'(accReady), 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         stalls = (i == stallLane) ? stallCycles : (randStall ? int'($urandom_range(0, 2)) : 0);
         mTready = 1'b0;
         for (int s = 0; s < stalls; s++) begin
            checkOutput("stall_tvalid", longint'(mTvalid), 1);
            checkOutput("stall_tdata", longint'($signed(mTdata)), expV[i]);
            checkOutput("stall_ready", longint'(accReady), 0);
            tick();
         end
         mTready = 1'b1;
         checkOutput("beat_tvalid", longint'(mTvalid), 1);
         checkOutput("beat_tdata", longint'($signed(mTdata)), expV[i]);
         checkOutput("beat_tlast", longint'(mTlast), longint'(last && i == 3));
         checkOutput("beat_ready", longint'(accReady), 0);
         tick();
         if (i == abortAfter) begin
            aresetn = 1'b0;
            #1;
            checkIdleOutputs("abort");
            #2;
            aresetn = 1'b1;
            tick();
            checkOutput("abort_ready", longint'(accReady), 1);
            return;
         end
      end
      checkOutput("idle_ready", longint'(accReady), 1);
      checkOutput("idle_tvalid", longint'(mTvalid), 0);
      checkOutput("idle_busy", longint'(busy), 0);
   endtask

   initial begin
      int vals[4];
      int sh;
      $display("[TB] start");
      repeat (3) tick();
      checkIdleOutputs("reset");
      aresetn = 1'b1;
      tick();
      checkOutput("reset_ready", longint'(accReady), 1);

      applyStimulus('{1000, -1000, 7, -8}, 4, 1'b0, -1, 0, 1'b0, -1);
      applyStimulus('{32'h7FFF_FFFF, 32'h8000_0000, 40000, -40000}, 0, 1'b0, -1, 0, 1'b0, -1);
      applyStimulus('{5, -5, 123456, -123456}, 3, 1'b0, 1, 5, 1'b0, -1);
      applyStimulus('{100, 200, 300, 400}, 1, 1'b0, -1, 0, 1'b0, -1);
      applyStimulus('{-100, -200, -300, -400}, 2, 1'b1, -1, 0, 1'b0, -1);
      applyStimulus('{11, 22, 33, 44}, 0, 1'b1, -1, 0, 1'b0, 1);
      applyStimulus('{9, 8, 7, 6}, 0, 1'b1, -1, 0, 1'b0, -1);
      applyStimulus('{-1000, 1000, -1, 0}, 4, 1'b0, -1, 0, 1'b0, -1);
      applyStimulus('{32'h7FFF_FFFF, -24, 24, 32'h8000_0000}, 31, 1'b1, -1, 0, 1'b0, -1);

      for (int k = 0; k < 24; k++) begin
         for (int j = 0; j < 4; j++) begin
            if ($urandom_range(0, 3) == 0) vals[j] = int'($urandom);
            else vals[j] = int'($urandom_range(0, 400000)) - 200000;
         end
         sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 8));
         applyStimulus(vals, sh, 1'($urandom_range(0, 1)), -1, 0, 1'b1, -1);
      end

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule

// File: doc/acc_requant_tx.md
ACC_REQUANT_TX -- requirements
Module: acc_requant_tx

Interface
REQ-001 SHALL have parameter LANES, default 4, number of 32-bit accumulator lanes per pack.
REQ-002 SHALL have parameter SHIFT_W, default 5, width of the requant shift amount.
REQ-003 SHALL have port aclk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port acc_valid  input  1  accumulator pack offered.
REQ-006 SHALL have port acc_ready  output  1  block can accept a pack.
REQ-007 SHALL have port acc_4pack  input  32*LANES  packed accumulators, lane i at bits [i*32 +: 32], two's complement.
REQ-008 SHALL have port acc_last  input  1  pack is the final one of an output tile.
REQ-009 SHALL have port shift  input  SHIFT_W  arithmetic right-shift amount, 0..31.
REQ-010 SHALL have port m_axis_tdata  output  16  requantized signed lane value.
REQ-011 SHALL have port m_axis_tvalid  output  1  AXI-Stream valid.
REQ-012 SHALL have port m_axis_tready  input  1  AXI-Stream ready.
REQ-013 SHALL have port m_axis_tlast  output  1  final beat of tile.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> QUANT -> SEND -> IDLE.
REQ-016 acc_ready SHALL be 1 only in IDLE; acceptance = acc_valid && acc_ready.
REQ-017 On acceptance SHALL register acc_4pack, acc_last and shift, and move to QUANT.
REQ-018 QUANT SHALL last exactly one cycle, register all LANES 16-bit results, clear lane counter, enter SEND.
REQ-019 Per lane: shift==0 -> value unchanged; else (acc + 2^(shift-1)) >>> shift, computed at 33 bits (round half up, no add overflow).
REQ-020 Result SHALL saturate to [-32768, 32767].
REQ-021 In SEND m_axis_tvalid SHALL be 1 and m_axis_tdata SHALL be result[lane]; lanes sent in order 0..LANES-1.
REQ-022 Lane counter SHALL advance only on m_axis_tvalid && m_axis_tready; tdata/tlast SHALL be stable while stalled.
REQ-023 m_axis_tlast SHALL be 1 only on lane LANES-1 of a pack captured with acc_last=1.
REQ-024 Handshake of lane LANES-1 SHALL return FSM to IDLE; acc_ready rises next cycle.
REQ-025 First tvalid SHALL appear 2 cycles after acceptance; min pack period LANES+2 cycles.
REQ-026 Changes on shift/acc_4pack after acceptance SHALL not affect the pack in flight.

Reset
REQ-027 aresetn low SHALL force IDLE, lane counter 0, acc_ready 1 after release, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, busy 0.
REQ-028 Reset mid-SEND SHALL discard the pack; no further beats of it emitted.

Configuration
REQ-029 Macro ACC_REQUANT_RELU_EN defined: after saturation negative results SHALL be replaced by 0.
REQ-030 Macro undefined: signed saturated results SHALL be output unchanged.

Structure
REQ-031 Shared package pe_pkg SHALL hold ACC_W=32, OUT_W=16, LANES default, and the FSM state type.
REQ-032 Sub-module requant_lane SHALL implement REQ-019/020/029 combinationally for one lane; instantiated LANES times.

Verification
REQ-033 Lanes {1000,-1000,7,-8}, shift=4, tready=1 -> beats 63, -62, 0, 0; tvalid 2 cycles after accept.
REQ-034 Lanes {0x7FFFFFFF,0x80000000,40000,-40000}, shift=0 -> 32767, -32768, 32767, -32768.
REQ-035 tready held 0 for 5 cycles on lane 1 -> tdata/tvalid stable, no lane skipped or repeated, acc_ready 0 throughout.
REQ-036 Two packs, second with acc_last=1 -> tlast only on 8th beat; acc_ready 0 from accept until the cycle after each 4th beat.
REQ-037 aresetn pulsed low after lane 1 handshake -> tvalid 0 immediately, next pack's beats start at its own lane 0.
REQ-038 With ACC_REQUANT_RELU_EN, lanes {-1000,1000,-1,0}, shift=4 -> 0, 63, 0, 0.
